// File: rtl/pulse_capture.sv
// pulse_capture: timestamps edges of an async pulse against the PWM tick counter and reports width/period via valid/ack
module pulse_capture #(
  parameter int bitwidth = 10,
  parameter int sync_stages = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [bitwidth-1:0] counter_value,
  input  logic                measured_signal,
  input  logic                capture_ack,
  output logic [bitwidth-1:0] tick_number_rising_edge,
  output logic [bitwidth-1:0] tick_number_falling_edge,
  output logic [bitwidth-1:0] pulse_width,
  output logic [bitwidth-1:0] pulse_period,
  output logic                period_known,
  output logic                capture_valid,
  output logic                overrun
);
  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, WAIT_FALL} state_t;
  state_t state, state_next;
  logic [sync_stages-1:0] sync, primed;
  logic [sync_stages-1:0][bitwidth-1:0] count_delay;
  logic [bitwidth-1:0] edge_tick, rise_tick, prev_rise, period_work;
  logic level, level_prev, rise, fall, start, done, prev_known, known_work;
  assign level = sync[sync_stages-1];
  assign edge_tick = count_delay[sync_stages-1];
  assign rise = level & ~level_prev;
  assign fall = ~level & level_prev;
  // primed marks that the last synchronizer flop holds a real sample rather than reset residue
  always_comb begin
    start = enable && state == WAIT_RISE && rise;
    done = enable && state == WAIT_FALL && fall;
    state_next = !enable ? WAIT_LOW :
                 state == WAIT_LOW ? (primed[sync_stages-1] && !level ? WAIT_RISE : WAIT_LOW) :
                 start ? WAIT_FALL :
                 done ? WAIT_RISE : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT_LOW;
      sync <= '0;
      primed <= '0;
      count_delay <= '0;
      level_prev <= 1'b0;
      rise_tick <= '0;
      prev_rise <= '0;
      period_work <= '0;
      prev_known <= 1'b0;
      known_work <= 1'b0;
      tick_number_rising_edge <= '0;
      tick_number_falling_edge <= '0;
      pulse_width <= '0;
      pulse_period <= '0;
      period_known <= 1'b0;
      capture_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      sync <= {sync[sync_stages-2:0], measured_signal};
      primed <= {primed[sync_stages-2:0], 1'b1};
      count_delay <= {count_delay[sync_stages-2:0], counter_value};
      level_prev <= level;
      if (!enable) prev_known <= 1'b0;
      if (start) begin
        rise_tick <= edge_tick;
        prev_rise <= edge_tick;
        prev_known <= 1'b1;
        period_work <= prev_known ? edge_tick - prev_rise : '0;
        known_work <= prev_known;
      end
      if (done && (!capture_valid || capture_ack)) begin
        tick_number_rising_edge <= rise_tick;
        tick_number_falling_edge <= edge_tick;
        pulse_width <= edge_tick - rise_tick;
        pulse_period <= period_work;
        period_known <= known_work;
        capture_valid <= 1'b1;
      end else if (capture_ack) capture_valid <= 1'b0;
      if (done && capture_valid && !capture_ack) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture: scoreboard bench comparing pulse_capture against a tick-level pulse model
module tb_pulse_capture;
  localparam int W = 10;
  localparam int S = 2;
  localparam int M = 1 << W;
  typedef struct { int rise; int fall; int width; int period; int known; } res_t;
  logic clock = 0, reset = 1, enable = 1, measured_signal = 0, mon_ack = 0, stim_ack = 0, capture_ack;
  logic [W-1:0] counter_value = '0;
  logic [W-1:0] tick_number_rising_edge, tick_number_falling_edge, pulse_width, pulse_period;
  logic period_known, capture_valid, overrun;
  res_t exp_q[$];
  res_t a, b, c, e;
  int total = 0, bad = 0, prev_rise = 0, prev_known = 0;
  bit auto_ack = 1;
  assign capture_ack = mon_ack | stim_ack;
  pulse_capture #(.bitwidth(W), .sync_stages(S)) dut (
    .clock(clock), .reset(reset), .enable(enable), .counter_value(counter_value),
    .measured_signal(measured_signal), .capture_ack(capture_ack),
    .tick_number_rising_edge(tick_number_rising_edge), .tick_number_falling_edge(tick_number_falling_edge),
    .pulse_width(pulse_width), .pulse_period(pulse_period), .period_known(period_known),
    .capture_valid(capture_valid), .overrun(overrun)
  );
  always #5 clock = ~clock;
  initial forever begin
    @(negedge clock);
    counter_value = counter_value + 1'b1;
  end
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  // returns just after the negedge whose counter value the next posedge will sample
  task automatic wait_neg(input int t);
    for (int n = 0; n < 3 * M; n++) begin
      @(negedge clock);
      #1;
      if (int'(counter_value) == t % M) return;
    end
    bad++;
    $display("FAIL wait_tick: counter never reached %0d", t % M);
  endtask
  task automatic wait_pos(input int t);
    for (int n = 0; n < 3 * M; n++) begin
      @(posedge clock);
      if (int'(counter_value) == t % M) begin
        #1;
        return;
      end
    end
    bad++;
    $display("FAIL wait_edge: counter never reached %0d", t % M);
  endtask
  task automatic pulse(input int r, input int f, input bit keep, output res_t res);
    r = r % M;
    f = f % M;
    wait_neg(r);
    measured_signal = 1;
    res.rise = r;
    res.known = prev_known;
    res.period = prev_known != 0 ? (r - prev_rise + M) % M : 0;
    prev_rise = r;
    prev_known = 1;
    wait_neg(f);
    measured_signal = 0;
    res.fall = f;
    res.width = (f - r + M) % M;
    if (keep) exp_q.push_back(res);
  endtask
  task automatic drain();
    for (int n = 0; n < 50 && (exp_q.size() != 0 || capture_valid); n++) @(negedge clock);
    check("drain", exp_q.size(), 0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_rise"}, tick_number_rising_edge, 0);
    check({tag, "_fall"}, tick_number_falling_edge, 0);
    check({tag, "_width"}, pulse_width, 0);
    check({tag, "_period"}, pulse_period, 0);
    check({tag, "_known"}, period_known, 0);
    check({tag, "_valid"}, capture_valid, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask
  // monitor: a new result is on the outputs when valid rises or reloads in an ack cycle
  initial begin
    res_t m;
    bit ack_seen, valid_last;
    valid_last = 0;
    forever begin
      @(posedge clock);
      ack_seen = capture_ack;
      #1;
      mon_ack = 0;
      if (capture_valid && (!valid_last || ack_seen)) begin
        if (exp_q.size() == 0) check("unexpected_result", tick_number_rising_edge, -1);
        else begin
          m = exp_q.pop_front();
          check("rise", tick_number_rising_edge, m.rise);
          check("fall", tick_number_falling_edge, m.fall);
          check("width", pulse_width, m.width);
          check("period", pulse_period, m.period);
          check("period_known", period_known, m.known);
        end
        if (auto_ack) mon_ack = 1;
      end
      valid_last = capture_valid;
    end
  end
  initial begin
    repeat (4) @(negedge clock);
    check_zero("reset");
    reset = 0;
    pulse(100, 350, 1, e);
    wait_pos(351);
    check("latency_e1", capture_valid, 0);
    @(posedge clock);
    #1;
    check("latency_e2", capture_valid, 1);
    drain();
    @(negedge clock);
    stim_ack = 1;
    @(negedge clock);
    stim_ack = 0;
    check("idle_ack_valid", capture_valid, 0);
    check("idle_ack_overrun", overrun, 0);
    pulse(600, 700, 1, e);
    drain();
    pulse(1000, 40, 1, e);
    drain();
    pulse(100, 100, 1, e);
    drain();
    auto_ack = 0;
    pulse(300, 320, 1, a);
    wait_pos(323);
    check("hold_a_overrun", overrun, 0);
    pulse(400, 420, 0, b);
    wait_pos(423);
    check("drop_overrun", overrun, 1);
    check("drop_valid", capture_valid, 1);
    check("drop_keep_rise", tick_number_rising_edge, a.rise);
    check("drop_keep_width", pulse_width, a.width);
    pulse(500, 530, 1, c);
    wait_neg(532);
    stim_ack = 1;
    wait_neg(533);
    stim_ack = 0;
    @(posedge clock);
    #1;
    check("same_cycle_valid", capture_valid, 1);
    check("same_cycle_overrun", overrun, 1);
    check("same_cycle_rise", tick_number_rising_edge, c.rise);
    enable = 0;
    prev_known = 0;
    repeat (3) @(negedge clock);
    check("disable_valid", capture_valid, 1);
    check("disable_fall", tick_number_falling_edge, c.fall);
    enable = 1;
    @(negedge clock);
    stim_ack = 1;
    @(negedge clock);
    stim_ack = 0;
    check("manual_ack_valid", capture_valid, 0);
    auto_ack = 1;
    wait_neg(200);
    measured_signal = 1;
    prev_rise = 200;
    wait_neg(205);
    enable = 0;
    prev_known = 0;
    wait_neg(215);
    measured_signal = 0;
    wait_neg(225);
    enable = 1;
    pulse(300, 310, 1, e);
    drain();
    check("sticky_overrun", overrun, 1);
    reset = 1;
    measured_signal = 1;
    repeat (3) @(negedge clock);
    check_zero("midreset");
    reset = 0;
    prev_known = 0;
    wait_neg(20);
    measured_signal = 0;
    pulse(50, 60, 1, e);
    drain();
    for (int i = 0; i < 20; i++) begin
      int r, f;
      r = int'(counter_value) + int'($urandom_range(20, 150));
      f = r + int'($urandom_range(1, 400));
      pulse(r, f, 1, e);
    end
    drain();
    check("final_overrun", overrun, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
